// File: rtl/quan_pkg.sv
// Shared definitions for the quantisation stage: mode encodings, the E loader
// FSM states and the E-register slot map used when replaying fetched E words.
package quan_pkg;

  localparam int E_word_width = 512;

  localparam logic [3:0] QMODE_E16 = 4'd0;
  localparam logic [3:0] QMODE_E32 = 4'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } ld_state_t;

  typedef struct packed {
    logic [7:0] start;
    logic [7:0] size;
    logic       last;
  } e_slot_t;

  // Slot window covered by word idx; 1-based starts so the 64 slots are 1..64.
  function automatic e_slot_t e_slot(input logic [3:0] m, input logic [1:0] idx);
    e_slot_t s;
    s = '{start: 8'd0, size: 8'd0, last: 1'b1};
    case (m)
      QMODE_E16: begin
        s.start = idx[0] ? 8'd33 : 8'd1;
        s.size  = 8'd32;
        s.last  = (idx == 2'd1);
      end
      QMODE_E32: begin
        s.start = 8'd1 + {2'b00, idx, 4'b0000};
        s.size  = 8'd16;
        s.last  = (idx == 2'd3);
      end
      default: s = '{start: 8'd0, size: 8'd0, last: 1'b1};
    endcase
    return s;
  endfunction

endpackage

// File: rtl/quan_e_loader.sv
// Tile-start loader: fetches 2 or 4 E words and replays each as an E_set write
// into quan_E_Regs_v2. Define QUAN_E_LOADER_TIMEOUT_EN to add a WAIT watchdog.
// Handshake: rd_req is held with a stable rd_addr until a cycle with rd_gnt;
// exactly one read is then outstanding and completes on the first rd_valid in WAIT.
module quan_e_loader #(
  parameter int E_word_width   = quan_pkg::E_word_width,
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [3:0]              mode_in,
  input  logic [ADDR_W-1:0]       base_addr,
  output logic                    rd_req,
  output logic [ADDR_W-1:0]       rd_addr,
  input  logic                    rd_gnt,
  input  logic                    rd_valid,
  input  logic [E_word_width-1:0] rd_data,
  output logic                    E_set,
  output logic [3:0]              mode,
  output logic [E_word_width-1:0] E_word,
  output logic [7:0]              E_reg_start,
  output logic [7:0]              E_reg_size,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);
  import quan_pkg::*;

  ld_state_t state, state_next;
  logic      fail_next;
  logic [1:0] idx;
  e_slot_t   slot_cur;
  logic      timeout;

  assign slot_cur = e_slot(mode, idx);

`ifdef QUAN_E_LOADER_TIMEOUT_EN
  logic [15:0] wait_cnt;

  assign timeout = (state == ST_WAIT) && (wait_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || state != ST_WAIT) wait_cnt <= '0;
    else                         wait_cnt <= wait_cnt + 16'd1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_next = state;
    fail_next  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (mode_in == QMODE_E16 || mode_in == QMODE_E32) begin
            state_next = ST_REQ;
          end else begin
            state_next = ST_DONE;
            fail_next  = 1'b1;
          end
        end
      end
      ST_REQ:   if (rd_gnt) state_next = ST_WAIT;
      ST_WAIT: begin
        // A word arriving in the watchdog's last cycle still wins.
        if (rd_valid) begin
          state_next = ST_WRITE;
        end else if (timeout) begin
          state_next = ST_DONE;
          fail_next  = 1'b1;
        end
      end
      ST_WRITE: state_next = slot_cur.last ? ST_DONE : ST_REQ;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      rd_req      <= 1'b0;
      rd_addr     <= '0;
      E_set       <= 1'b0;
      mode        <= '0;
      E_word      <= '0;
      E_reg_start <= '0;
      E_reg_size  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state  <= state_next;
      busy   <= (state_next != ST_IDLE);
      rd_req <= (state_next == ST_REQ);
      E_set  <= (state_next == ST_WRITE);
      done   <= (state_next == ST_DONE);
      err    <= (state_next == ST_DONE) && fail_next;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode    <= mode_in;
            rd_addr <= base_addr;
            idx     <= '0;
          end
        end
        ST_WAIT: begin
          if (rd_valid) begin
            E_word      <= rd_data;
            E_reg_start <= slot_cur.start;
            E_reg_size  <= slot_cur.size;
          end
        end
        ST_WRITE: begin
          if (!slot_cur.last) begin
            idx     <= idx + 2'd1;
            rd_addr <= rd_addr + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_quan_e_loader.sv
// Directed bench for quan_e_loader: a read responder models the E buffer, and
// monitors check granted addresses and E_set writes against expected queues.
module tb_quan_e_loader;
  localparam int W  = 512;
  localparam int AW = 16;
  localparam int EW = W + 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [3:0]    mode_in;
  logic [AW-1:0] base_addr;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_gnt;
  logic          rd_valid;
  logic [W-1:0]  rd_data;
  logic          E_set;
  logic [3:0]    mode;
  logic [W-1:0]  E_word;
  logic [7:0]    E_reg_start;
  logic [7:0]    E_reg_size;
  logic          busy;
  logic          done;
  logic          err;

  quan_e_loader #(.E_word_width(W), .ADDR_W(AW), .TIMEOUT_CYCLES(10)) dut (
    .clk(clk), .rst(rst), .start(start), .mode_in(mode_in), .base_addr(base_addr),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid),
    .rd_data(rd_data), .E_set(E_set), .mode(mode), .E_word(E_word),
    .E_reg_start(E_reg_start), .E_reg_size(E_reg_size), .busy(busy), .done(done),
    .err(err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  int checks = 0;
  int failures = 0;

  logic [AW-1:0] exp_addr_q[$];
  logic [EW-1:0] exp_q[$];
  int gnt_count = 0;
  int eset_count = 0;

  // responder controls
  int gnt_delay = 0;
  int valid_delay = 2;
  bit withhold = 1'b0;
  bit spurious = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] data_of(input logic [AW-1:0] a);
    return {16{a, ~a}};
  endfunction

  // ---------------- E buffer responder ----------------
  initial begin
    logic [AW-1:0] a;
    rd_gnt = 1'b0;
    rd_valid = 1'b0;
    rd_data = '0;
    forever begin
      tick();
      if (rd_req) begin
        a = rd_addr;
        for (int i = 0; i < gnt_delay; i++) begin
          if (spurious && i == 0) begin
            rd_valid = 1'b1;
            rd_data = {W{1'b1}};
          end
          tick();
          rd_valid = 1'b0;
        end
        rd_gnt = 1'b1;
        tick();
        rd_gnt = 1'b0;
        for (int i = 1; i < valid_delay; i++) tick();
        while (withhold) tick();
        rd_valid = 1'b1;
        rd_data = data_of(a);
        tick();
        rd_valid = 1'b0;
      end
    end
  end

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if (rd_req && rd_gnt) begin
      gnt_count++;
      if (exp_addr_q.size() == 0) begin
        chk("unexpected_read", {48'd0, rd_addr}, 64'hDEAD);
      end else begin
        chk("rd_addr", {48'd0, rd_addr}, {48'd0, exp_addr_q.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (E_set) begin
      eset_count++;
      if (exp_q.size() == 0) begin
        chk("unexpected_e_set", {48'd0, E_reg_start, E_reg_size}, 64'hDEAD);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (E_word !== e[EW-1:16]) begin
          failures++;
          $display("FAIL e_word actual=%0h required=%0h", E_word[63:0], e[79:16]);
        end
        chk("e_reg_start", {56'd0, E_reg_start}, {56'd0, e[15:8]});
        chk("e_reg_size", {56'd0, E_reg_size}, {56'd0, e[7:0]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_exp(input logic [3:0] m, input logic [AW-1:0] base,
                          input int n_addr, input int n_word);
    logic [7:0] st0 [2];
    logic [7:0] st1 [4];
    logic [AW-1:0] a;
    st0 = '{8'd1, 8'd33};
    st1 = '{8'd1, 8'd17, 8'd33, 8'd49};
    for (int i = 0; i < n_addr; i++) exp_addr_q.push_back(base + AW'(i));
    for (int i = 0; i < n_word; i++) begin
      a = base + AW'(i);
      if (m == 4'd0) exp_q.push_back({data_of(a), st0[i], 8'd32});
      else           exp_q.push_back({data_of(a), st1[i], 8'd16});
    end
  endtask

  // Start a load; k counts cycles after the start-sampling edge.
  task automatic run_load(input string name, input logic [3:0] m, input logic [AW-1:0] base,
                          input int n_addr, input int n_word, input int exp_k,
                          input bit exp_err, input bit repulse);
    int k;
    bit seen;
    bit req_seen;
    push_exp(m, base, n_addr, n_word);
    tick();
    start = 1'b1;
    mode_in = m;
    base_addr = base;
    tick();
    start = 1'b0;
    mode_in = 4'd0;
    base_addr = '0;
    k = 0;
    seen = 1'b0;
    req_seen = 1'b0;
    for (int c = 1; c <= 200 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk({name, "_req_t1"}, {63'd0, rd_req}, {63'd0, (m < 4'd2)});
        chk({name, "_mode"}, {60'd0, mode}, {60'd0, m});
      end
      if (rd_req) req_seen = 1'b1;
      if (repulse && c == 3) begin
        start = 1'b1;
        mode_in = 4'd1;
        base_addr = 16'h7777;
        tick();
        start = 1'b0;
        mode_in = 4'd0;
        base_addr = '0;
      end
      if (done) begin
        seen = 1'b1;
        k = c;
      end
    end
    chk({name, "_done_cycle"}, 64'(k), 64'(exp_k));
    chk({name, "_err"}, {63'd0, err}, {63'd0, exp_err});
    if (m >= 4'd2) chk({name, "_no_req"}, {63'd0, req_seen}, 64'd0);
    @(negedge clk);
    chk({name, "_busy_after"}, {62'd0, busy, done}, 64'd0);
    chk({name, "_addr_q_left"}, 64'(exp_addr_q.size()), 64'd0);
    chk({name, "_e_q_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base_g;
    int base_e;
    rst = 1'b1;
    start = 1'b0;
    mode_in = '0;
    base_addr = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_ctrl", {59'd0, rd_req, E_set, busy, done, err}, 64'd0);
    chk("rst_data", {32'd0, rd_addr, E_reg_start, E_reg_size}, 64'd0);
    chk("rst_word", {60'd0, mode}, 64'd0);
    chk("rst_eword_zero", {63'd0, (E_word == '0)}, 64'd1);
    tick();
    rst = 1'b0;
    repeat (2) tick();

    // mode 0, immediate grant, data one cycle into WAIT: 4 cycles/word + DONE
    gnt_delay = 0; valid_delay = 2;
    run_load("m0", 4'd0, 16'h0100, 2, 2, 9, 1'b0, 1'b0);

    // mode 1 across the address wrap, grant delayed 3 cycles
    gnt_delay = 3; valid_delay = 2;
    run_load("m1_wrap", 4'd1, 16'hFFFE, 4, 4, 29, 1'b0, 1'b0);

    // unsupported mode: straight to DONE with err
    run_load("m5", 4'd5, 16'h0400, 0, 0, 1, 1'b1, 1'b0);

    // clean reference, then same run with start re-pulse and a spurious valid in REQ
    gnt_delay = 1; valid_delay = 2;
    run_load("m1_clean", 4'd1, 16'h0500, 4, 4, 21, 1'b0, 1'b0);
    spurious = 1'b1;
    run_load("m1_noise", 4'd1, 16'h0500, 4, 4, 21, 1'b0, 1'b1);
    spurious = 1'b0;

    // reset in WAIT of word 2
    gnt_delay = 0; valid_delay = 2;
    push_exp(4'd1, 16'h0200, 2, 1);
    base_g = gnt_count;
    base_e = eset_count;
    tick();
    start = 1'b1; mode_in = 4'd1; base_addr = 16'h0200;
    tick();
    start = 1'b0; mode_in = 4'd0; base_addr = '0;
    for (int c = 0; c < 50 && eset_count == base_e; c++) @(negedge clk);
    withhold = 1'b1;
    for (int c = 0; c < 50 && gnt_count < base_g + 2; c++) @(negedge clk);
    chk("rst_mid_gnts", 64'(gnt_count - base_g), 64'd2);
    @(negedge clk);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_ctrl", {59'd0, rd_req, E_set, busy, done, err}, 64'd0);
    chk("rst_mid_data", {28'd0, mode, rd_addr, E_reg_start, E_reg_size}, 64'd0);
    chk("rst_mid_eword_zero", {63'd0, (E_word == '0)}, 64'd1);
    withhold = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("rst_mid_quiet", {62'd0, done, busy}, 64'd0);
    end
    run_load("m1_reload", 4'd1, 16'h0200, 4, 4, 17, 1'b0, 1'b0);

`ifdef QUAN_E_LOADER_TIMEOUT_EN
    // watchdog: grant at once, data never arrives -> DONE after 10 WAIT cycles
    withhold = 1'b1;
    run_load("timeout", 4'd0, 16'h0300, 1, 0, 12, 1'b1, 1'b0);
    withhold = 1'b0;
    repeat (4) tick();
`endif

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
